// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state type and small decode helpers.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide
// on a 2*WIDTH accumulator. Purely combinational.
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;

    // Divide leaves the new quotient slot (LSB) clear; the caller ORs q_bit in.
    always_comb begin
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, operand};
        q_bit     = 1'b0;
        acc_next  = {add_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            q_bit    = ~rem_diff[WIDTH];
            acc_next = {(q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_md.sv
// Iterative signed/unsigned multiply/divide unit with architectural HI/LO,
// MTHI/MTLO writes and a busy stall for the execute stage.
module alu_md import md_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a request sampled only in IDLE; busy is the inverse
    // of ready, and upstream holds start/md_op/a/b stalled while busy is high.
    md_state_t          state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, step_acc;
    logic [WIDTH-1:0]   opnd, a_mag, b_mag;
    logic               op_div, neg_res, neg_rem, dz, step_q;
    logic               accept, mt_hi, mt_lo, fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // Negating the most-negative value wraps to itself, i.e. 2^(WIDTH-1) unsigned.
    assign a_mag = (is_signed_op(md_op) && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed_op(md_op) && b[WIDTH-1]) ? -b : b;

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .is_div   (op_div),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        fix        = 1'b0;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_iter_op(md_op)) begin
                            accept     = 1'b1;
                            state_next = ST_RUN;
                        end else if (md_op == MD_MTHI) begin
                            mt_hi = 1'b1;
                        end else if (md_op == MD_MTLO) begin
                            mt_lo = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_W'(1)) state_next = ST_FIX;
                end
                ST_FIX: begin
                    fix        = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // With a zero divisor the remainder path ends holding |a|; the dividend-sign
    // fixup then restores a exactly, so HI <- a needs no special case.
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            op_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            div0    <= 1'b0;
        end else begin
            done <= fix;
            div0 <= fix & dz;
            if (accept) begin
                cnt     <= CNT_W'(WIDTH);
                op_div  <= is_div_op(md_op);
                neg_res <= is_signed_op(md_op) & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem <= is_signed_op(md_op) & a[WIDTH-1];
                dz      <= is_div_op(md_op) & (b == '0);
                if (is_div_op(md_op)) begin
                    acc  <= {{WIDTH{1'b0}}, a_mag};
                    opnd <= b_mag;
                end else begin
                    acc  <= {{WIDTH{1'b0}}, b_mag};
                    opnd <= a_mag;
                end
            end else if (state == ST_RUN) begin
                cnt <= cnt - CNT_W'(1);
                acc <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
            end
            if (mt_hi) hi <= a;
            if (mt_lo) lo <= a;
            if (fix) begin
                if (op_div) begin
                    lo <= dz ? '1 : quot_fix;
                    hi <= rem_fix;
                end else begin
                    {hi, lo} <= prod_fix;
                end
            end
        end
    end

endmodule
